// File: rtl/fx3_pkg.sv
// Shared types and constants for the FX3 slave-FIFO device model.
// Pin strobes are active low; decode_strobes folds chip select into each strobe.
package fx3_pkg;

  localparam int RD_LATENCY = 2;
  localparam logic STROBE_ON = 1'b0;

  typedef struct packed {
    logic last;
    logic zlp;
  } tag_t;

  typedef struct packed {
    logic rd;
    logic wr;
    logic pktend;
    logic oe;
  } strobe_t;

  function automatic strobe_t decode_strobes(input logic slcs_b, input logic slrd_b,
                                             input logic slwr_b, input logic pktend_b,
                                             input logic sloe_b);
    strobe_t s;
    logic cs;
    cs       = (slcs_b == STROBE_ON);
    s.rd     = cs && (slrd_b == STROBE_ON);
    s.wr     = cs && (slwr_b == STROBE_ON);
    s.pktend = cs && (pktend_b == STROBE_ON);
    s.oe     = cs && (sloe_b == STROBE_ON);
    return s;
  endfunction

endpackage

// File: rtl/fx3_socket_fifo.sv
// One FX3 socket: circular buffer with wrap-bit pointers and per-entry last/zlp tags.
// The caller decides when to push, pop or retro-tag the newest entry as last.
module fx3_socket_fifo
  import fx3_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  tag_t                  push_tag,
  input  logic                  pop,
  input  logic                  tag_last,
  output logic [DATA_WIDTH-1:0] pop_data,
  output tag_t                  pop_tag,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  newest_last
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DEPTH_LOG2:0]   wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  tag_t                  tags [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_idx, rd_idx, newest_idx;
  logic                  do_push, do_pop;

  assign wr_idx      = wr_ptr[DEPTH_LOG2-1:0];
  assign rd_idx      = rd_ptr[DEPTH_LOG2-1:0];
  assign newest_idx  = wr_idx - 1'b1;
  assign count       = wr_ptr - rd_ptr;
  assign full        = (count == (DEPTH_LOG2+1)'(DEPTH));
  assign empty       = (count == '0);
  assign newest_last = tags[newest_idx].last;
  assign pop_data    = mem[rd_idx];
  assign pop_tag     = tags[rd_idx];

  // A pop on the same edge frees the slot, so a full socket still accepts a push
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) tags[i] <= '0;
    end else begin
      if (do_push) begin
        wr_ptr       <= wr_ptr + 1'b1;
        tags[wr_idx] <= push_tag;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (tag_last) tags[newest_idx].last <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_idx] <= push_data;
  end

endmodule

// File: rtl/fx3_slave_fifo_multi.sv
// FX3 slave-FIFO device model: N sockets, pin-side handshake, host fill/drain port
// and sticky protocol-error flags. All pin decisions use the address registered one cycle earlier.
module fx3_slave_fifo_multi
  import fx3_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SOCKETS = 4,
  parameter int ADDR_WIDTH = 2,
  parameter int DEPTH_LOG2 = 8,
  parameter logic [NUM_SOCKETS-1:0] SOCKET_IS_IN = 4'b0001,
  parameter int WATERMARK = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [ADDR_WIDTH-1:0]                fx3_fifo_addr,
  input  logic                                 fx3_slcs_b,
  input  logic                                 fx3_slrd_b,
  input  logic                                 fx3_slwr_b,
  input  logic                                 fx3_sloe_b,
  input  logic                                 fx3_pktend_b,
  input  logic [DATA_WIDTH-1:0]                fx3_fd_in,
  output logic [DATA_WIDTH-1:0]                fx3_fd_out,
  output logic                                 fx3_fd_oe,
  output logic                                 fx3_dma_rdy,
  input  logic                                 host_wr_en,
  input  logic [ADDR_WIDTH-1:0]                host_wr_socket,
  input  logic [DATA_WIDTH-1:0]                host_wr_data,
  output logic                                 host_wr_full,
  input  logic                                 host_rd_en,
  input  logic [ADDR_WIDTH-1:0]                host_rd_socket,
  output logic                                 host_rd_valid,
  output logic [DATA_WIDTH-1:0]                host_rd_data,
  output logic                                 host_rd_last,
  output logic                                 host_rd_zlp,
  output logic [NUM_SOCKETS*(DEPTH_LOG2+1)-1:0] host_count,
  input  logic                                 err_clear,
  output logic [NUM_SOCKETS-1:0]               err_overrun,
  output logic [NUM_SOCKETS-1:0]               err_underrun,
  output logic [NUM_SOCKETS-1:0]               err_dir
);

  localparam int CW = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [ADDR_WIDTH-1:0]  sel;
  strobe_t                stb;
  logic [NUM_SOCKETS-1:0] fpga_hit, wr_hit, rd_hit;
  logic [NUM_SOCKETS-1:0] push, pop, tag_last, full, empty, newest_last;
  logic [NUM_SOCKETS-1:0] set_over, set_under, set_dir;
  logic [DATA_WIDTH-1:0]  push_data [NUM_SOCKETS];
  tag_t                   push_tag [NUM_SOCKETS];
  logic [DATA_WIDTH-1:0]  pop_data [NUM_SOCKETS];
  tag_t                   pop_tag [NUM_SOCKETS];
  logic [CW-1:0]          count [NUM_SOCKETS];
  logic                   rd_fire, host_fire, rdy_next;
  logic [DATA_WIDTH-1:0]  rd_word, host_word;
  tag_t                   host_tag;
  logic [RD_LATENCY-1:0]  pipe_vld;
  logic [DATA_WIDTH-1:0]  pipe_data [RD_LATENCY];

  assign stb = decode_strobes(fx3_slcs_b, fx3_slrd_b, fx3_slwr_b, fx3_pktend_b, fx3_sloe_b);

  always_comb begin
    fpga_hit = '0;
    wr_hit   = '0;
    rd_hit   = '0;
    for (int s = 0; s < NUM_SOCKETS; s++) begin
      fpga_hit[s] = (sel == ADDR_WIDTH'(s));
      wr_hit[s]   = (host_wr_socket == ADDR_WIDTH'(s));
      rd_hit[s]   = (host_rd_socket == ADDR_WIDTH'(s));
    end
  end

  // IN sockets are filled from the pins and drained by the host; OUT sockets the reverse
  always_comb begin
    push = '0; pop = '0; tag_last = '0;
    set_over = '0; set_under = '0; set_dir = '0;
    rd_fire = 1'b0; rd_word = '0;
    host_fire = 1'b0; host_word = '0; host_tag = '0;
    rdy_next = 1'b0;
    host_wr_full = 1'b1;
    for (int s = 0; s < NUM_SOCKETS; s++) begin
      push_data[s] = '0;
      push_tag[s]  = '0;
      if (SOCKET_IS_IN[s]) begin
        pop[s] = rd_hit[s] && host_rd_en;
        if (pop[s] && !empty[s]) begin
          host_fire = 1'b1;
          host_word = pop_data[s];
          host_tag  = pop_tag[s];
        end
        if (fpga_hit[s]) begin
          rdy_next   = ((DEPTH - int'(count[s])) >= WATERMARK);
          set_dir[s] = stb.rd;
          if (stb.wr) begin
            push[s]           = 1'b1;
            push_data[s]      = fx3_fd_in;
            push_tag[s].last  = stb.pktend;
          end else if (stb.pktend) begin
            // Retro-tag only an entry that is still in the buffer after this edge
            if (!empty[s] && !newest_last[s] && !(pop[s] && count[s] == CW'(1)))
              tag_last[s] = 1'b1;
            else begin
              push[s]          = 1'b1;
              push_tag[s].last = 1'b1;
              push_tag[s].zlp  = 1'b1;
            end
          end
          set_over[s] = push[s] && full[s] && !pop[s];
        end
      end else begin
        push[s]      = wr_hit[s] && host_wr_en;
        push_data[s] = host_wr_data;
        if (fpga_hit[s]) begin
          rdy_next   = (count[s] != '0);
          pop[s]     = stb.rd;
          set_dir[s] = stb.wr || stb.pktend;
          if (stb.rd && empty[s]) set_under[s] = 1'b1;
          else if (stb.rd) begin
            rd_fire = 1'b1;
            rd_word = pop_data[s];
          end
        end
      end
      if (wr_hit[s]) host_wr_full = full[s];
    end
  end

  for (genvar s = 0; s < NUM_SOCKETS; s++) begin : g_socket
    fx3_socket_fifo #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH_LOG2(DEPTH_LOG2)
    ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push[s]),
      .push_data  (push_data[s]),
      .push_tag   (push_tag[s]),
      .pop        (pop[s]),
      .tag_last   (tag_last[s]),
      .pop_data   (pop_data[s]),
      .pop_tag    (pop_tag[s]),
      .count      (count[s]),
      .full       (full[s]),
      .empty      (empty[s]),
      .newest_last(newest_last[s])
    );
    assign host_count[s*CW +: CW] = count[s];
  end

  // fd_out only moves when a popped word reaches the end of the read pipe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel           <= '0;
      fx3_dma_rdy   <= 1'b0;
      fx3_fd_oe     <= 1'b0;
      fx3_fd_out    <= '0;
      pipe_vld      <= '0;
      for (int i = 0; i < RD_LATENCY; i++) pipe_data[i] <= '0;
      host_rd_valid <= 1'b0;
      host_rd_data  <= '0;
      host_rd_last  <= 1'b0;
      host_rd_zlp   <= 1'b0;
      err_overrun   <= '0;
      err_underrun  <= '0;
      err_dir       <= '0;
    end else begin
      sel          <= fx3_fifo_addr;
      fx3_dma_rdy  <= rdy_next;
      fx3_fd_oe    <= stb.oe;
      pipe_vld     <= {pipe_vld[RD_LATENCY-2:0], rd_fire};
      pipe_data[0] <= rd_word;
      for (int i = 1; i < RD_LATENCY; i++) pipe_data[i] <= pipe_data[i-1];
      if (pipe_vld[RD_LATENCY-1]) fx3_fd_out <= pipe_data[RD_LATENCY-1];
      host_rd_valid <= host_fire;
      if (host_fire) begin
        host_rd_data <= host_word;
        host_rd_last <= host_tag.last;
        host_rd_zlp  <= host_tag.zlp;
      end
      if (err_clear) begin
        err_overrun  <= '0;
        err_underrun <= '0;
        err_dir      <= '0;
      end else begin
        err_overrun  <= err_overrun | set_over;
        err_underrun <= err_underrun | set_under;
        err_dir      <= err_dir | set_dir;
      end
    end
  end

endmodule

// File: tb/tb_fx3_slave_fifo_multi.sv
// Directed bench for fx3_slave_fifo_multi with 8-deep sockets, socket 0 IN and sockets 1-3 OUT.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_fx3_slave_fifo_multi;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  fx3_fifo_addr;
  logic        fx3_slcs_b, fx3_slrd_b, fx3_slwr_b, fx3_sloe_b, fx3_pktend_b;
  logic [31:0] fx3_fd_in;
  logic [31:0] fx3_fd_out;
  logic        fx3_fd_oe, fx3_dma_rdy;
  logic        host_wr_en;
  logic [1:0]  host_wr_socket;
  logic [31:0] host_wr_data;
  logic        host_wr_full;
  logic        host_rd_en;
  logic [1:0]  host_rd_socket;
  logic        host_rd_valid;
  logic [31:0] host_rd_data;
  logic        host_rd_last, host_rd_zlp;
  logic [15:0] host_count;
  logic        err_clear;
  logic [3:0]  err_overrun, err_underrun, err_dir;

  int checks = 0;
  int errors = 0;

  fx3_slave_fifo_multi #(
    .DATA_WIDTH(32),
    .NUM_SOCKETS(4),
    .ADDR_WIDTH(2),
    .DEPTH_LOG2(3),
    .SOCKET_IS_IN(4'b0001),
    .WATERMARK(4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .fx3_fifo_addr (fx3_fifo_addr),
    .fx3_slcs_b    (fx3_slcs_b),
    .fx3_slrd_b    (fx3_slrd_b),
    .fx3_slwr_b    (fx3_slwr_b),
    .fx3_sloe_b    (fx3_sloe_b),
    .fx3_pktend_b  (fx3_pktend_b),
    .fx3_fd_in     (fx3_fd_in),
    .fx3_fd_out    (fx3_fd_out),
    .fx3_fd_oe     (fx3_fd_oe),
    .fx3_dma_rdy   (fx3_dma_rdy),
    .host_wr_en    (host_wr_en),
    .host_wr_socket(host_wr_socket),
    .host_wr_data  (host_wr_data),
    .host_wr_full  (host_wr_full),
    .host_rd_en    (host_rd_en),
    .host_rd_socket(host_rd_socket),
    .host_rd_valid (host_rd_valid),
    .host_rd_data  (host_rd_data),
    .host_rd_last  (host_rd_last),
    .host_rd_zlp   (host_rd_zlp),
    .host_count    (host_count),
    .err_clear     (err_clear),
    .err_overrun   (err_overrun),
    .err_underrun  (err_underrun),
    .err_dir       (err_dir)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [3:0] cnt(input int s);
    return host_count[s*4 +: 4];
  endfunction

  initial begin
    reset = 1'b1;
    fx3_fifo_addr = 2'd0;
    fx3_slcs_b = 1'b1; fx3_slrd_b = 1'b1; fx3_slwr_b = 1'b1;
    fx3_sloe_b = 1'b1; fx3_pktend_b = 1'b1; fx3_fd_in = '0;
    host_wr_en = 1'b0; host_wr_socket = 2'd0; host_wr_data = '0;
    host_rd_en = 1'b0; host_rd_socket = 2'd0; err_clear = 1'b0;
    step(); step();
    check_output("rst_fd_oe", fx3_fd_oe, 0);
    check_output("rst_dma_rdy", fx3_dma_rdy, 0);
    check_output("rst_count", host_count, 0);
    check_output("rst_rd_valid", host_rd_valid, 0);
    check_output("rst_fd_out", fx3_fd_out, 0);
    check_output("rst_errs", {err_overrun, err_underrun, err_dir}, 0);

    reset = 1'b0; fx3_slcs_b = 1'b0; fx3_sloe_b = 1'b0;
    step();
    check_output("fd_oe_on", fx3_fd_oe, 1);

    // OUT socket 1: host fills, FPGA pulls three words
    host_wr_en = 1'b1; host_wr_socket = 2'd1;
    host_wr_data = 32'h11; step();
    host_wr_data = 32'h22; step();
    host_wr_data = 32'h33; step();
    host_wr_en = 1'b0;
    check_output("out_count3", cnt(1), 3);
    check_output("out_not_full", host_wr_full, 0);
    fx3_fifo_addr = 2'd1; step(); step();
    check_output("out_rdy", fx3_dma_rdy, 1);
    fx3_slrd_b = 1'b0; step();
    check_output("lat_t0", fx3_fd_out, 0);
    step();
    check_output("lat_t1", fx3_fd_out, 0);
    step();
    fx3_slrd_b = 1'b1;
    check_output("rd_0x11", fx3_fd_out, 32'h11);
    check_output("rdy_still", fx3_dma_rdy, 1);
    check_output("out_count0", cnt(1), 0);
    step();
    check_output("rd_0x22", fx3_fd_out, 32'h22);
    check_output("rdy_drop", fx3_dma_rdy, 0);
    step();
    check_output("rd_0x33", fx3_fd_out, 32'h33);
    step();
    check_output("fd_hold", fx3_fd_out, 32'h33);

    // Empty read and wrong-direction write on socket 1
    fx3_slrd_b = 1'b0; step(); fx3_slrd_b = 1'b1;
    check_output("underrun", err_underrun, 4'b0010);
    step(); step();
    check_output("underrun_hold", fx3_fd_out, 32'h33);
    fx3_slwr_b = 1'b0; step(); fx3_slwr_b = 1'b1;
    check_output("dir_err", err_dir, 4'b0010);
    check_output("dir_count", cnt(1), 0);
    err_clear = 1'b1; step(); err_clear = 1'b0;
    check_output("clr_under", err_underrun, 0);
    check_output("clr_dir", err_dir, 0);

    // IN socket 0: watermark, overrun, drain
    fx3_fifo_addr = 2'd0; step();
    for (int i = 1; i <= 5; i++) begin
      fx3_fd_in = i; fx3_slwr_b = 1'b0; step();
      if (i == 4) check_output("in_rdy_4", fx3_dma_rdy, 1);
    end
    fx3_slwr_b = 1'b1; step();
    check_output("in_rdy_low", fx3_dma_rdy, 0);
    check_output("in_count5", cnt(0), 5);
    for (int i = 6; i <= 9; i++) begin
      fx3_fd_in = i; fx3_slwr_b = 1'b0; step();
    end
    fx3_slwr_b = 1'b1;
    check_output("in_count8", cnt(0), 8);
    check_output("overrun", err_overrun, 4'b0001);
    err_clear = 1'b1; step(); err_clear = 1'b0;
    check_output("clr_over", err_overrun, 0);
    host_rd_socket = 2'd0; host_rd_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      check_output($sformatf("drain_%0d", i), host_rd_data, i);
      if (i == 1) check_output("drain_valid", host_rd_valid, 1);
    end
    step();
    check_output("pop_empty", host_rd_valid, 0);
    host_rd_en = 1'b0;

    // pktend with write, then pktend alone -> ZLP
    fx3_fd_in = 32'hA; fx3_slwr_b = 1'b0; fx3_pktend_b = 1'b0; step();
    fx3_slwr_b = 1'b1; step();
    fx3_pktend_b = 1'b1;
    check_output("zlp_count", cnt(0), 2);
    host_rd_en = 1'b1; step();
    check_output("pe_data", host_rd_data, 32'hA);
    check_output("pe_tags", {host_rd_last, host_rd_zlp}, 2'b10);
    step();
    check_output("zlp_data", host_rd_data, 0);
    check_output("zlp_tags", {host_rd_last, host_rd_zlp}, 2'b11);
    host_rd_en = 1'b0; step();
    check_output("zlp_done", host_rd_valid, 0);

    // pktend alone retro-tags the newest word
    fx3_fd_in = 32'hB; fx3_slwr_b = 1'b0; step();
    fx3_fd_in = 32'hC; step();
    fx3_slwr_b = 1'b1; fx3_pktend_b = 1'b0; step();
    fx3_pktend_b = 1'b1;
    check_output("tag_count", cnt(0), 2);
    host_rd_en = 1'b1; step();
    check_output("tag_b", {host_rd_data, host_rd_last}, {32'hB, 1'b0});
    step();
    check_output("tag_c", {host_rd_data, host_rd_last, host_rd_zlp}, {32'hC, 2'b10});
    host_rd_en = 1'b0; step();

    // Asynchronous reset in the middle of activity
    for (int i = 1; i <= 5; i++) begin
      fx3_fd_in = 32'h50 + i; fx3_slwr_b = 1'b0; step();
    end
    fx3_slwr_b = 1'b1;
    host_wr_en = 1'b1; host_wr_socket = 2'd1; host_wr_data = 32'h77; step();
    host_wr_en = 1'b0;
    fx3_fifo_addr = 2'd1; step(); step();
    check_output("pre_rst_count", cnt(0), 5);
    check_output("pre_rst_rdy", fx3_dma_rdy, 1);
    check_output("pre_rst_oe", fx3_fd_oe, 1);
    #2 reset = 1'b1;
    #1;
    check_output("async_count", host_count, 0);
    check_output("async_rdy", fx3_dma_rdy, 0);
    check_output("async_oe", fx3_fd_oe, 0);
    step();
    reset = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
